// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one Adder counter between NB_REQ requesters and returns post-op values.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
//
// state | meaning
// IDLE  | arbitrate, assert req_ready to the winner
// ISSUE | one-cycle inc/clr pulse into the Adder
// WAIT  | Adder has updated, capture its output
// RESP  | hold response until rsp_ready
module adder_arbiter #(
   parameter int WIDTH  = 8,
   parameter int NB_REQ = 4,
   parameter int IDW    = $clog2(NB_REQ)
) (
   input  logic              aclk,
   input  logic              arst,
   input  logic [NB_REQ-1:0] req_valid,
   input  logic [NB_REQ-1:0] req_op,
   output logic [NB_REQ-1:0] req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              adder_inc,
   output logic              adder_clr,
   input  logic [WIDTH-1:0]  adder_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] gnt_sel;
   logic [IDW-1:0] gnt_id;
   logic           gnt_op;
   logic [IDW-1:0] off;
   logic           any_req;

   assign any_req = |req_valid;

`ifdef ADDER_ARB_FIXED_PRIO_EN
   always_comb begin
      off = '0;
      for (int i = NB_REQ-1; i >= 0; i--)
         if (req_valid[i]) off = IDW'(i);
   end

   assign gnt_sel = off;
`else
   logic [IDW-1:0]      rr_ptr;
   logic [2*NB_REQ-1:0] req_dbl;
   logic [NB_REQ-1:0]   req_rot;
   logic [IDW:0]        gnt_sum;

   // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit is then the winner offset.
   assign req_dbl = {req_valid, req_valid};
   assign req_rot = req_dbl[{1'b0, rr_ptr} +: NB_REQ];

   always_comb begin
      off = '0;
      for (int i = NB_REQ-1; i >= 0; i--)
         if (req_rot[i]) off = IDW'(i);
   end

   always_comb begin
      gnt_sum = {1'b0, rr_ptr} + {1'b0, off};
      if (gnt_sum >= (IDW+1)'(NB_REQ))
         gnt_sum = gnt_sum - (IDW+1)'(NB_REQ);
   end

   assign gnt_sel = gnt_sum[IDW-1:0];

   always_ff @(posedge aclk or posedge arst) begin
      if (arst)
         rr_ptr <= '0;
      else if (state == IDLE && any_req)
         rr_ptr <= (gnt_sel == IDW'(NB_REQ-1)) ? '0 : gnt_sel + IDW'(1);
   end
`endif

   always_ff @(posedge aclk or posedge arst) begin
      if (arst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && any_req && !arst)
         req_ready[gnt_sel] = 1'b1;
   end

   assign adder_inc = (state == ISSUE) && !gnt_op;
   assign adder_clr = (state == ISSUE) && gnt_op;
   assign rsp_valid = (state == RESP);

   // The Adder registered the op on the ISSUE edge, so adder_out is current during WAIT.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         gnt_id   <= '0;
         gnt_op   <= 1'b0;
         rsp_id   <= '0;
         rsp_data <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            gnt_id <= gnt_sel;
            gnt_op <= req_op[gnt_sel];
         end
         if (state == WAIT) begin
            rsp_id   <= gnt_id;
            rsp_data <= adder_out;
         end
      end
   end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one Adder counter instance between NB_REQ requesters; each request is a single increment or clear.
- Arbitrates pending requests and drives one-cycle inc/clr pulses into the Adder.
- Captures the post-operation counter value and returns it with the winning requester's ID over a valid/ready response channel.
- Sits directly in front of the Adder, which is instantiated beside it at the same level.

Parameters:
- WIDTH, 8, counter width; must equal the Adder WIDTH.
- NB_REQ, 4, number of requesters, 2..16.
- IDW, $clog2(NB_REQ), response ID width (derived; do not override).

Ports:
- aclk  in  1  clock, all state on rising edge
- arst  in  1  reset, asynchronous, active-high
- req_valid  in  NB_REQ  per-requester request valid
- req_op  in  NB_REQ  per-requester operation: 0 = increment, 1 = clear
- req_ready  out  NB_REQ  per-requester accept, at most one bit high
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester being answered
- rsp_data  out  WIDTH  counter value after the operation
- adder_inc  out  1  to Adder inc
- adder_clr  out  1  to Adder clr
- adder_out  in  WIDTH  from Adder out

Behaviour:
- Reset (async on arst=1):
  - FSM = IDLE, rr_ptr = 0.
  - req_ready, rsp_valid, adder_inc, adder_clr all 0; rsp_id = 0; rsp_data = 0.
  - Any in-flight operation is dropped with no response.
  - The Adder must be reset by the same event; the integrator ties Adder arstn = ~arst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant g is chosen combinationally: the first set bit searching upward from rr_ptr, wrapping modulo NB_REQ.
  - req_ready[g] = 1 in the same cycle; all other ready bits are 0.
  - On that edge: latch g and req_op[g], set rr_ptr = (g+1) mod NB_REQ, go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with all ready bits 0.
- ISSUE:
  - adder_inc = ~op and adder_clr = op, for exactly one cycle.
  - Never both high. Go to WAIT.
- WAIT:
  - The Adder registered the operation on the ISSUE edge.
  - On this edge: register rsp_data <= adder_out and rsp_id <= g. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_data are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new grant while in RESP; back-pressure stalls all requesters.
- req_ready is only ever asserted in IDLE.
- Requesters hold req_valid and req_op stable until accepted. Deasserting req_valid before acceptance is legal and simply withdraws the request.
- Latency:
  - Acceptance to rsp_valid = 3 cycles.
  - Minimum 4 cycles per operation when rsp_ready is tied high.
- Arithmetic:
  - The arbiter performs none; rsp_data reflects Adder wrap-around (2^WIDTH-1 + 1 -> 0).
  - A clear returns 0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NB_REQ-1,0,...
- A single requester at index k is granted immediately regardless of rr_ptr.
- Reset asserted in any state returns to IDLE asynchronously. The first grant after release starts the search at index 0.

Optional Feature:
- Macro ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and rr_ptr is removed.
- Undefined (default): round-robin as above.
- All other FSM, latency and handshake behaviour is identical in both builds.

Test Plan:
- Reset, then requester 0 issues inc x3 with rsp_ready=1 -> responses rsp_id=0 with rsp_data=1,2,3. Each rsp_valid occurs 3 cycles after its req_ready. adder_inc is a single-cycle pulse and adder_clr stays 0.
- Requesters 0..3 all valid (inc) from the same cycle -> grant order 0,1,2,3 and rsp_data 1,2,3,4. With ADDER_ARB_FIXED_PRIO_EN the order is 0,0,0... for as long as requester 0 stays valid.
- Counter at 5; requester 2 issues clr -> rsp_id=2, rsp_data=0, adder_clr pulsed once, adder_inc=0.
- 255 incs with WIDTH=8, then one more inc -> rsp_data=255, then 0 (wrap).
- rsp_ready held low 10 cycles while requester 1 is valid -> rsp_valid stays 1, rsp_id and rsp_data stable, req_ready stays 0. Grant occurs only after the response handshake completes.
- arst pulsed during WAIT -> rsp_valid never asserts and all outputs are 0. A subsequent request from requester 3 gets rsp_data=1 (Adder also reset).
